// File: rtl/dual_beam_pkg.sv
// Shared widths, types and helpers for the dual-beam power trigger.
package dual_beam_pkg;

  localparam int unsigned NBITS  = 5;
  localparam int unsigned NSAMP  = 8;
  localparam int unsigned NCHAN  = 8;
  localparam int unsigned TWIDTH = 18;

  localparam int unsigned BEAMW = NCHAN * NSAMP * NBITS;
  localparam int unsigned SUMW  = 8;
  localparam int unsigned PRODW = 2 * SUMW;
  localparam int unsigned SQW   = 15;
  localparam int unsigned NPART = NSAMP / 2;
  localparam int unsigned PARTW = 16;
  localparam int unsigned PWRW  = 18;

  localparam logic [TWIDTH-1:0] THRESH_RST = TWIDTH'('h3FFFF);

  typedef logic signed [NBITS-1:0] samp_t;
  typedef logic signed [SUMW-1:0]  sum_t;
  typedef logic        [SQW-1:0]   sq_t;
  typedef logic        [PARTW-1:0] part_t;
  typedef logic        [PWRW-1:0]  pwr_t;
  typedef logic        [TWIDTH-1:0] thresh_t;

  // Offset binary to two's complement: x - 16 is just an MSB flip.
  function automatic samp_t to_signed(input logic [NBITS-1:0] x);
    return samp_t'({~x[NBITS-1], x[NBITS-2:0]});
  endfunction

  // Square of a channel sum; |v| <= 128 so the result fits in SQW bits.
  function automatic sq_t square(input sum_t v);
    return SQW'(PRODW'(v) * PRODW'(v));
  endfunction

endpackage

// File: rtl/dual_beam_power_trigger_if.sv
// Beam data, threshold staging and trigger bus of the power trigger.
interface dual_beam_power_trigger_if;
  import dual_beam_pkg::*;

  logic [BEAMW-1:0]  beamA_i;
  logic [BEAMW-1:0]  beamB_i;
  logic [TWIDTH-1:0] thresh_i;
  logic [1:0]        thresh_ce_i;
  logic              update_i;
  logic [1:0]        trigger_o;

  modport master (
    output beamA_i, beamB_i, thresh_i, thresh_ce_i, update_i,
    input  trigger_o
  );

  modport slave (
    input  beamA_i, beamB_i, thresh_i, thresh_ce_i, update_i,
    output trigger_o
  );

endinterface

// File: rtl/beam_power_unit.sv
// One beam: offset conversion, channel sum, square, sample sum and a
// threshold comparison against a double-buffered threshold.
module beam_power_unit
  import dual_beam_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BEAMW-1:0] beam_i,
  input  thresh_t          thresh_i,
  input  logic             thresh_ce_i,
  input  logic             update_i,
  output logic             trigger_o
);

  samp_t   samp_q [NCHAN][NSAMP];
  sum_t    sum_d  [NSAMP];
  sum_t    sum_q  [NSAMP];
  sq_t     sq_q   [NSAMP];
  part_t   part_d [NPART];
  part_t   part_q [NPART];
  pwr_t    pwr_d;
  pwr_t    pwr_q;
  thresh_t pend_q;
  thresh_t act_q;

  // Channel sum per sample; 8 values in -16..15 stay within 8-bit signed.
  always_comb begin
    for (int s = 0; s < NSAMP; s++) begin
      sum_d[s] = '0;
      for (int c = 0; c < NCHAN; c++) begin
        sum_d[s] = sum_d[s] + SUMW'(samp_q[c][s]);
      end
    end
  end

  // Power is summed as a two-level adder tree, one register per level.
  always_comb begin
    pwr_d = '0;
    for (int i = 0; i < NPART; i++) begin
      part_d[i] = PARTW'(sq_q[2*i]) + PARTW'(sq_q[2*i+1]);
      pwr_d     = pwr_d + PWRW'(part_q[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_q <= '{default: '0};
      sum_q  <= '{default: '0};
      sq_q   <= '{default: '0};
      part_q <= '{default: '0};
      pwr_q  <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        for (int s = 0; s < NSAMP; s++) begin
          samp_q[c][s] <= to_signed(beam_i[NBITS*(NSAMP*c+s) +: NBITS]);
        end
      end
      for (int s = 0; s < NSAMP; s++) begin
        sum_q[s] <= sum_d[s];
        sq_q[s]  <= square(sum_q[s]);
      end
      part_q <= part_d;
      pwr_q  <= pwr_d;
    end
  end

  // Update copies the pending value held before this edge, not a same-cycle load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q    <= THRESH_RST;
      act_q     <= THRESH_RST;
      trigger_o <= 1'b0;
    end else begin
      if (thresh_ce_i) pend_q <= thresh_i;
      if (update_i)    act_q  <= pend_q;
      trigger_o <= (pwr_q > act_q);
    end
  end

endmodule

// File: rtl/dual_beam_power_trigger.sv
// Two independent beam power units sharing threshold staging controls.
module dual_beam_power_trigger
  import dual_beam_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  dual_beam_power_trigger_if.slave   bus
);

  logic trig_a;
  logic trig_b;

  beam_power_unit u_beam_a (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .beam_i      (bus.beamA_i),
    .thresh_i    (bus.thresh_i),
    .thresh_ce_i (bus.thresh_ce_i[0]),
    .update_i    (bus.update_i),
    .trigger_o   (trig_a)
  );

  beam_power_unit u_beam_b (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .beam_i      (bus.beamB_i),
    .thresh_i    (bus.thresh_i),
    .thresh_ce_i (bus.thresh_ce_i[1]),
    .update_i    (bus.update_i),
    .trigger_o   (trig_b)
  );

  assign bus.trigger_o = {trig_b, trig_a};

endmodule

// File: tb/tb_dual_beam_power_trigger.sv
// Randomised and directed checks of the dual-beam power trigger against a power/threshold model.
module tb_dual_beam_power_trigger;
  import dual_beam_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dual_beam_power_trigger_if bus ();

  dual_beam_power_trigger dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Model state: powers in flight (5-deep delay) and threshold registers.
  int unsigned pqa[$];
  int unsigned pqb[$];
  int unsigned m_pend[2];
  int unsigned m_act[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned beam_power(input logic [BEAMW-1:0] b);
    int unsigned p = 0;
    for (int s = 0; s < NSAMP; s++) begin
      int sum = 0;
      for (int c = 0; c < NCHAN; c++) begin
        logic [NBITS-1:0] x;
        x   = b[NBITS*(NSAMP*c+s) +: NBITS];
        sum = sum + int'(x) - 16;
      end
      p = p + int'(sum * sum);
    end
    return p;
  endfunction

  function automatic logic [BEAMW-1:0] per_samp(input logic [NSAMP-1:0][NBITS-1:0] v);
    logic [BEAMW-1:0] out;
    for (int c = 0; c < NCHAN; c++)
      for (int s = 0; s < NSAMP; s++)
        out[NBITS*(NSAMP*c+s) +: NBITS] = v[s];
    return out;
  endfunction

  function automatic logic [BEAMW-1:0] all_x(input int x);
    logic [NSAMP-1:0][NBITS-1:0] v;
    for (int s = 0; s < NSAMP; s++) v[s] = NBITS'(x);
    return per_samp(v);
  endfunction

  function automatic logic [BEAMW-1:0] rand_beam();
    logic [BEAMW-1:0] b;
    for (int w = 0; w < BEAMW / 32; w++) b[32*w +: 32] = $urandom();
    return b;
  endfunction

  task automatic model_reset();
    pqa.delete();
    pqb.delete();
    for (int i = 0; i < 5; i++) begin
      pqa.push_back(0);
      pqb.push_back(0);
    end
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 32'h3FFFF;
      m_act[b]  = 32'h3FFFF;
    end
  endtask

  task automatic drive(input logic [BEAMW-1:0] a, input logic [BEAMW-1:0] b,
                       input int unsigned th, input logic [1:0] ce, input logic upd);
    bus.beamA_i     = a;
    bus.beamB_i     = b;
    bus.thresh_i    = TWIDTH'(th);
    bus.thresh_ce_i = ce;
    bus.update_i    = upd;
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic cycle();
    logic [1:0] exp;
    @(posedge clk);
    exp[0] = pqa[0] > m_act[0];
    exp[1] = pqb[0] > m_act[1];
    void'(pqa.pop_front());
    void'(pqb.pop_front());
    pqa.push_back(beam_power(bus.beamA_i));
    pqb.push_back(beam_power(bus.beamB_i));
    if (bus.update_i) begin
      m_act[0] = m_pend[0];
      m_act[1] = m_pend[1];
    end
    for (int b = 0; b < 2; b++)
      if (bus.thresh_ce_i[b]) m_pend[b] = int'(bus.thresh_i);
    #1;
    check("trig", 32'(bus.trigger_o), 32'(exp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int unsigned th, input logic [1:0] ce);
    logic [BEAMW-1:0] a, b;
    a = bus.beamA_i;
    b = bus.beamB_i;
    drive(a, b, th, ce, 1'b0);
    cycle();
    drive(a, b, th, 2'b00, 1'b1);
    cycle();
    drive(a, b, th, 2'b00, 1'b0);
  endtask

  initial begin
    logic [NSAMP-1:0][NBITS-1:0] va, vb;
    rst_n = 1'b0;
    drive('0, '0, 0, 2'b00, 1'b0);
    model_reset();
    #12;
    check("rst_hold", 32'(bus.trigger_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero inputs give the maximum power but the reset threshold is above it.
    run(10);
    load(32'h0FFFF, 2'b01);
    load(32'h0F000, 2'b10);
    run(7);
    check("zero_both", 32'(bus.trigger_o), 32'd3);

    for (int s = 0; s < NSAMP; s++) va[s] = NBITS'(8 + s);
    drive(per_samp(va), all_x(8), 0, 2'b00, 1'b0);
    run(7);
    check("ramp_a_x8_b", 32'(bus.trigger_o), 32'd0);
    drive(per_samp(va), all_x(24), 0, 2'b00, 1'b0);
    run(7);
    drive(per_samp(va), all_x(16), 0, 2'b00, 1'b0);
    run(7);
    drive(all_x(31), all_x(31), 0, 2'b00, 1'b0);
    run(7);
    check("all31", 32'(bus.trigger_o), 32'd3);
    for (int s = 0; s < NSAMP; s++) begin
      va[s] = (s < 4) ? NBITS'(15) : NBITS'(16);
      vb[s] = (s < 4) ? NBITS'(16) : NBITS'(15);
    end
    drive(per_samp(va), per_samp(vb), 0, 2'b00, 1'b0);
    run(7);
    check("half_ones", 32'(bus.trigger_o), 32'd0);

    // Boundary on beam B with power exactly 32768.
    drive('0, all_x(8), 0, 2'b00, 1'b0);
    load(32768, 2'b10);
    run(7);
    check("bnd_equal", 32'(bus.trigger_o[1]), 32'd0);
    load(32767, 2'b10);
    run(7);
    check("bnd_below", 32'(bus.trigger_o[1]), 32'd1);

    // Staging: pending only, then ce+update together, then a second update.
    drive('0, all_x(8), 40000, 2'b10, 1'b0);
    cycle();
    drive('0, all_x(8), 0, 2'b00, 1'b0);
    run(7);
    check("pend_only", 32'(bus.trigger_o[1]), 32'd1);
    drive('0, all_x(8), 100, 2'b10, 1'b1);
    cycle();
    drive('0, all_x(8), 0, 2'b00, 1'b0);
    run(7);
    check("ce_upd_old", 32'(bus.trigger_o[1]), 32'd0);
    drive('0, all_x(8), 0, 2'b00, 1'b1);
    cycle();
    drive('0, all_x(8), 0, 2'b00, 1'b0);
    run(7);
    check("second_upd", 32'(bus.trigger_o[1]), 32'd1);

    // Asynchronous reset mid-stream clears the trigger and the thresholds.
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(bus.trigger_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(10);
    check("rst_thresh", 32'(bus.trigger_o), 32'd0);

    // Random traffic: mixed noise and flat beams, random staging.
    for (int i = 0; i < 600; i++) begin
      logic [BEAMW-1:0] a, b;
      int unsigned th;
      a  = ($urandom_range(0, 2) == 0) ? all_x(int'($urandom_range(0, 31))) : rand_beam();
      b  = ($urandom_range(0, 2) == 0) ? all_x(int'($urandom_range(0, 31))) : rand_beam();
      th = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 140000) : $urandom_range(0, 12000);
      drive(a, b, th, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            ($urandom_range(0, 4) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_beam_power_trigger.md
Name: dual_beam_power_trigger

Overview:
Power trigger stage for two beams (A and B). Each beam carries 8 channels × 8 samples of 5-bit offset-binary data per clock. For each beam, the block sums across channels, squares each per-sample sum, and adds the 8 squares to get a power value per clock. Each power is compared against its own double-buffered threshold, giving one trigger bit per beam for the downstream trigger logic.

Parameters:
NBITS, 5, sample width (offset binary: signed value = x − 16, range −16..+15)
NSAMP, 8, samples per channel per clock
NCHAN, 8, channels summed per beam
TWIDTH, 18, threshold/power width

Ports:
clk_i  in  1  system clock; everything is synchronous to it
rst_ni  in  1  asynchronous active-low reset
beamA_i  in  NCHAN*NSAMP*NBITS (320)  beam A; channel c sample s at bit offset NBITS*NSAMP*c + NBITS*s
beamB_i  in  320  beam B; same packing as beamA_i
thresh_i  in  TWIDTH  threshold value to stage
thresh_ce_i  in  2  staging enables: bit0 → beam A pending, bit1 → beam B pending
update_i  in  1  copy both pending thresholds into the active thresholds
trigger_o  out  2  bit0 = beam A trigger, bit1 = beam B trigger (registered)

Behaviour:
- Reset (async assert, sync release): trigger_o=0. Pending and active thresholds = 18'h3FFFF, which no power value can exceed. All pipeline registers = 0.
- Sample conversion: s = x − 16, done by inverting the MSB to form signed two's complement.
- Stage 1: register the converted inputs.
- Stage 2: per sample, signed sum over 8 channels. Range −128..+120, 8-bit signed (9-bit container permitted).
- Stage 3: square each sum. Max 16384, 15-bit unsigned.
- Stage 4: add the 8 squares to get power. Max 131072, fits in 18 bits. No saturation is needed.
- Stage 5: trigger_o[b] <= (power_b > active_thresh_b), unsigned strict greater-than. Equality does not trigger.
- Latency: inputs sampled at edge N produce trigger_o at edge N+5. Fully pipelined; a new result every clock; no handshake.
- Threshold staging:
  - On a clock with thresh_ce_i[b]=1: pending_b <= thresh_i.
  - On a clock with update_i=1: active_A <= pending_A and active_B <= pending_B.
  - ce and update in the same cycle: update copies the old pending value. The new value needs a further update, so a load always takes at least 2 clocks.
  - Both ce bits set: both pending registers load the same value.
- The new active threshold is used by the comparator from the clock after the update edge.
- Beams A and B are fully independent apart from the shared thresh_i/update_i.

Decomposition:
- Package dual_beam_pkg: NBITS, NSAMP, NCHAN, TWIDTH; derived widths (SUMW=8, SQW=15, PWRW=18); reset threshold constant 18'h3FFFF.
- One sub-module, beam_power_unit, instantiated twice. It contains:
  - offset conversion
  - channel sum
  - square
  - sample sum
  - pending/active threshold registers
  - comparator
- Its ports: clk_i, rst_ni, beam_i, thresh_i, thresh_ce_i (1 bit), update_i, trigger_o.

Test Plan:
- Reset with all inputs 0: trigger_o stays 2'b00 indefinitely, since active threshold 3FFFF > 131072.
- Load A=18'h0FFFF (ce=2'b01) then B=18'h0F000 (ce=2'b10), then update. All inputs 0 → power 131072 on both → trigger_o=2'b11 five clocks after the inputs apply.
- Thresholds as above. A channel samples x=8..15 (s=−8..−1) → power 13056 → bit0=0. B all x=8 → power 32768 < 61440 → bit1=0. B all x=24 → 32768 → bit1=0. B all x=16 → 0 → bit1=0.
- All inputs 31 → power 115200 on both → trigger_o=2'b11. Then A x=15,15,15,15,16,16,16,16 and B mirrored → power 256 each → trigger_o=2'b00.
- Boundary, B all x=8 (power 32768):
  - active B threshold 32768 → bit1=0
  - 32767 → bit1=1
- Staging: write pending with no update → trigger unchanged. Assert ce and update in the same cycle → old pending value applied. A second update applies the new value. Assert rst_ni mid-stream → trigger_o clears immediately and thresholds return to 3FFFF.
